vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/pixel_enable_gen.sv | 35 +++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and coordinate types for the VGA timing
// generator and the board renderer.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  // 640x480 @ ~59.5 Hz from a 100 MHz system clock
  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_VIS_START = 144;
  localparam int DEF_H_VIS       = 640;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_VIS_START = 35;
  localparam int DEF_V_VIS       = 480;

  // Board grid origins in raw hCount/vCount space, so the renderer and the
  // timing generator agree on where pixel (0,0) of the board sits.
  localparam int BLOCK_SIZE = 32;
  localparam int BOARD_X0   = DEF_H_VIS_START;
  localparam int BOARD_Y0   = DEF_V_VIS_START;

  // Inclusive unsigned window test on raster coordinates.
  function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/pixel_enable_gen.sv
// Divides the system clock into a one-cycle pixel enable every CLK_DIV clocks.
module pixel_enable_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pix_en_q, pix_en_d;

  // Next divider value; pix_en is high in the cycle the divider sits at LAST
  always_comb begin
    cnt_d    = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    pix_en_d = (cnt_d == LAST);
  end

  // Divider and registered enable
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pix_en_q <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel counters, sync/bright decode and frame-level ticks.
// Decode is taken from next-state counter values so every registered output
// lines up with hCount/vCount in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_VIS_START = DEF_H_VIS_START,
  parameter int H_VIS       = DEF_H_VIS,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_VIS_START = DEF_V_VIS_START,
  parameter int V_VIS       = DEF_V_VIS
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_start,
  output logic       vblank_tick
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 2");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10 bits");
  end
  if (H_VIS_START + H_VIS > H_TOTAL) begin : g_bad_hvis
    $error("vga_timing_gen: horizontal visible window exceeds H_TOTAL");
  end
  if (V_VIS_START + V_VIS > V_TOTAL) begin : g_bad_vvis
    $error("vga_timing_gen: vertical visible window exceeds V_TOTAL");
  end

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_SYNC_W = coord_t'(H_SYNC);
  localparam coord_t V_SYNC_W = coord_t'(V_SYNC);
  localparam coord_t H_VIS_LO = coord_t'(H_VIS_START);
  localparam coord_t H_VIS_HI = coord_t'(H_VIS_START + H_VIS - 1);
  localparam coord_t V_VIS_LO = coord_t'(V_VIS_START);
  localparam coord_t V_VIS_HI = coord_t'(V_VIS_START + V_VIS - 1);
  // First blanking line; absent when the visible window runs to V_TOTAL
  localparam coord_t VB_LINE  = coord_t'(V_VIS_START + V_VIS);
  localparam bit     VB_EN    = (V_VIS_START + V_VIS) < V_TOTAL;

  logic   pix_en_w;
  logic   line_wrap;
  coord_t h_count_q, h_count_d;
  coord_t v_count_q, v_count_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   bright_q, bright_d;
  logic   frame_start_q, frame_start_d;
  logic   vblank_tick_q, vblank_tick_d;

  pixel_enable_gen #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en_w)
  );

  // Next counter position, decode of that position, and wrap ticks
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    line_wrap = pix_en_w && (h_count_q == H_LAST);
    if (pix_en_w) begin
      if (line_wrap) begin
        h_count_d = '0;
        v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + 1'b1;
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end
    hsync_d       = !(h_count_d < H_SYNC_W);
    vsync_d       = !(v_count_d < V_SYNC_W);
    bright_d      = in_window(h_count_d, H_VIS_LO, H_VIS_HI) &&
                    in_window(v_count_d, V_VIS_LO, V_VIS_HI);
    frame_start_d = line_wrap && (v_count_q == V_LAST);
    vblank_tick_d = line_wrap && VB_EN && (v_count_d == VB_LINE);
  end

  // Raster state; reset parks at (0,0) with syncs deasserted and no ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      bright_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_tick_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
      vblank_tick_q <= vblank_tick_d;
    end
  end

  assign pix_en      = pix_en_w;
  assign hCount      = h_count_q;
  assign vCount      = v_count_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign bright      = bright_q;
  assign frame_start = frame_start_q;
  assign vblank_tick = vblank_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance and a small-raster
// instance, both checked every cycle against a closed-form reference built
// from the number of clocks since reset, plus directed timing measurements.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fs;
    logic       vb;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // default-timing instance
  logic       pe_d, hs_d, vs_d, br_d, fs_d, vb_d;
  logic [9:0] hc_d, vc_d;
  // small-raster instance
  logic       pe_s, hs_s, vs_s, br_s, fs_s, vb_s;
  logic [9:0] hc_s, vc_s;

  vga_timing_gen dut_d (
    .clk(clk), .reset(reset), .pix_en(pe_d), .hCount(hc_d), .vCount(vc_d),
    .hSync(hs_d), .vSync(vs_d), .bright(br_d), .frame_start(fs_d),
    .vblank_tick(vb_d)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(16), .H_SYNC(2), .H_VIS_START(4), .H_VIS(8),
    .V_TOTAL(8), .V_SYNC(1), .V_VIS_START(2), .V_VIS(4)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pe_s), .hCount(hc_s), .vCount(vc_s),
    .hSync(hs_s), .vSync(vs_s), .bright(br_s), .frame_start(fs_s),
    .vblank_tick(vb_s)
  );

  obs_t obs_d, obs_s;
  assign obs_d = {pe_d, hc_d, vc_d, hs_d, vs_d, br_d, fs_d, vb_d};
  assign obs_s = {pe_s, hc_s, vc_s, hs_s, vs_s, br_s, fs_s, vb_s};

  int   errors = 0;
  int   checks = 0;
  int   age = 0;
  obs_t q_d[$];
  obs_t q_s[$];

  // Expected outputs after `age` unreset edges (age 0 = the reset state).
  function automatic obs_t model(int a, int d, int ht, int hs, int hvs, int hv,
                                 int vt, int vs, int vvs, int vv);
    obs_t o;
    int nn, n, h, v;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (a == 0) return o;
    nn = a / d;
    n  = nn % (ht * vt);
    h  = n % ht;
    v  = n / ht;
    o.pix = (a % d) == d - 1;
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.hs  = h >= hs;
    o.vs  = v >= vs;
    o.br  = (h >= hvs) && (h < hvs + hv) && (v >= vvs) && (v < vvs + vv);
    o.fs  = (a % d == 0) && (nn > 0) && (n == 0);
    o.vb  = (a % d == 0) && (h == 0) && (v == vvs + vv);
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got pix=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b vb=%b, want pix=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b vb=%b",
             tag, obs.pix, obs.h, obs.v, obs.hs, obs.vs, obs.br, obs.fs, obs.vb,
             exp.pix, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.fs, exp.vb);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard producer: one expected sample per DUT per clock edge
  initial forever begin
    @(posedge clk);
    if (reset) age = 0;
    else age++;
    q_d.push_back(model(age, 4, 800, 96, 144, 640, 525, 2, 35, 480));
    q_s.push_back(model(age, 2, 16, 2, 4, 8, 8, 1, 2, 4));
  end

  // Scoreboard consumer: compare away from the active edge
  initial forever begin
    @(negedge clk);
    if (q_d.size() > 0) chk_obs("dflt", obs_d, q_d.pop_front());
    if (q_s.size() > 0) chk_obs("small", obs_s, q_s.pop_front());
  end

  initial begin
    int first_pe, h_at4, t, gap, tot, low, high;
    int nfs, nvb, vb_bad, first_fs, last_fs, gap_fs, vsl, brc;

    // 1. reset for 5 clocks, then release; pix_en cadence
    repeat (5) @(negedge clk);
    chk_obs("reset_hold_dflt", obs_d, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    first_pe = 0;
    h_at4 = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (pe_d && first_pe == 0) first_pe = i;
      if (i == 4) h_at4 = int'(hc_d);
    end
    chk_int("first_pix_en_cycle", first_pe, 3);
    chk_int("hcount_after_edge4", h_at4, 1);
    t = 0;
    while (!pe_d && t < 20) begin @(negedge clk); t++; end
    gap = 0;
    do begin @(negedge clk); gap++; end while (!pe_d && gap < 20);
    chk_int("pix_en_spacing", gap, 4);

    // 2. one full line (vCount==1) of the default raster
    t = 0;
    while (vc_d != 10'd1 && t < 4000) begin @(negedge clk); t++; end
    chk_int("reach_line1", int'(vc_d), 1);
    tot = 0; low = 0; high = 0;
    while (vc_d == 10'd1 && tot < 4000) begin
      tot++;
      if (!hs_d) low++; else high++;
      @(negedge clk);
    end
    chk_int("line_clks", tot, 3200);
    chk_int("hsync_low_clks", low, 384);
    chk_int("hsync_high_clks", high, 2816);
    chk_int("wrap_vcount", int'(vc_d), 2);
    chk_int("wrap_hcount", int'(hc_d), 0);

    // 3. reset the small raster mid-frame at (11,4) for one clock
    t = 0;
    while (!(hc_s == 10'd11 && vc_s == 10'd4) && t < 600) begin @(negedge clk); t++; end
    chk_int("reach_mid_frame", int'({vc_s, hc_s}), int'({10'd4, 10'd11}));
    reset = 1'b1;
    @(negedge clk);
    chk_obs("mid_reset_small", obs_s, {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;

    // 4. three frames after reset: two frame_starts, three vblank_ticks
    nfs = 0; nvb = 0; vb_bad = 0; first_fs = -1; last_fs = -1; gap_fs = 0;
    vsl = 0; brc = 0;
    for (int i = 1; i <= 767; i++) begin
      @(negedge clk);
      if (fs_s) begin
        nfs++;
        if (first_fs < 0) first_fs = i;
        if (last_fs >= 0) gap_fs = i - last_fs;
        last_fs = i;
      end
      if (vb_s) begin
        nvb++;
        if (hc_s != 10'd0 || vc_s != 10'd6) vb_bad++;
      end
      if (i >= 256) begin
        if (!vs_s) vsl++;
        if (br_s) brc++;
      end
    end
    chk_int("frame_start_count", nfs, 2);
    chk_int("first_frame_start", first_fs, 256);
    chk_int("frame_start_gap", gap_fs, 256);
    chk_int("vblank_count", nvb, 3);
    chk_int("vblank_position", vb_bad, 0);
    chk_int("vsync_low_2frames", vsl, 64);
    chk_int("bright_2frames", brc, 128);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
